// File: rtl/falafel_req_scheduler.sv
`default_nettype none
// ============================================================================
// falafel_req_scheduler - serializes alloc/free requests onto the allocator core
// Revision: 1.0
// ============================================================================
module falafel_req_scheduler #(
  parameter int                DATA_W      = 64,
  parameter int                MSG_ID_SIZE = 8,
  parameter logic [DATA_W-1:0] CFG_ADDR    = 'h10,
  parameter int                CNT_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_req_val_i,
  output logic                          alloc_req_rdy_o,
  input  logic [MSG_ID_SIZE+DATA_W-1:0] alloc_req_data_i,
  input  logic                          free_req_val_i,
  output logic                          free_req_rdy_o,
  input  logic [MSG_ID_SIZE+DATA_W-1:0] free_req_data_i,
  output logic                          core_req_val_o,
  input  logic                          core_req_rdy_i,
  output logic                          core_req_is_alloc_o,
  output logic [MSG_ID_SIZE+DATA_W-1:0] core_req_data_o,
  input  logic                          core_done_i,
  input  logic                          config_reg_write_i,
  input  logic [DATA_W-1:0]             config_reg_addr_i,
  input  logic [DATA_W-1:0]             config_reg_data_i,
  output logic                          busy_o,
  output logic                          error_o,
  output logic [CNT_W-1:0]              alloc_grant_cnt_o,
  output logic [CNT_W-1:0]              free_grant_cnt_o
);

  localparam int ENTRY_W = MSG_ID_SIZE + DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic                 last_alloc_q, last_alloc_d;
  logic [ENTRY_W-1:0]   hold_data_q, hold_data_d;
  logic                 hold_alloc_q, hold_alloc_d;
  logic                 core_val_q, core_val_d;
  logic                 error_q, error_d;
  logic [CNT_W-1:0]     alloc_cnt_q, alloc_cnt_d;
  logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;

  logic pick_alloc;
  logic pick_free;
  logic grant_alloc;
  logic grant_free;
  logic cfg_hit;
  logic cnt_clr;
  logic unused_cfg_bits;

  assign unused_cfg_bits = ^{config_reg_data_i[DATA_W-1:9], config_reg_data_i[7:1]};

  // Winner selection; pick_* already implies the corresponding valid.
  always_comb begin
    pick_alloc = 1'b0;
    pick_free  = 1'b0;
    if (mode_q) begin
      pick_free  = free_req_val_i;
      pick_alloc = alloc_req_val_i & ~free_req_val_i;
    end else if (alloc_req_val_i && free_req_val_i) begin
      pick_alloc = ~last_alloc_q;
      pick_free  = last_alloc_q;
    end else begin
      pick_alloc = alloc_req_val_i;
      pick_free  = free_req_val_i;
    end
  end

  assign grant_alloc = (state_q == IDLE) && !rst_i && pick_alloc;
  assign grant_free  = (state_q == IDLE) && !rst_i && pick_free;
  assign cfg_hit     = config_reg_write_i && (config_reg_addr_i == CFG_ADDR);
  assign cnt_clr     = cfg_hit && config_reg_data_i[8];

  always_comb begin
    state_d      = state_q;
    mode_d       = cfg_hit ? config_reg_data_i[0] : mode_q;
    last_alloc_d = last_alloc_q;
    hold_data_d  = hold_data_q;
    hold_alloc_d = hold_alloc_q;
    core_val_d   = core_val_q;
    error_d      = error_q;
    case (state_q)
      IDLE: begin
        if (core_done_i) error_d = 1'b1;
        if (grant_alloc || grant_free) begin
          state_d      = ISSUE;
          hold_data_d  = grant_alloc ? alloc_req_data_i : free_req_data_i;
          hold_alloc_d = grant_alloc;
          last_alloc_d = grant_alloc;
          core_val_d   = 1'b1;
        end
      end
      ISSUE: begin
        // A done here (even alongside the handshake) is a protocol violation.
        if (core_done_i) error_d = 1'b1;
        if (core_req_rdy_i) begin
          state_d    = WAIT_DONE;
          core_val_d = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (core_done_i) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        core_val_d = 1'b0;
      end
    endcase
  end

  // A clear in the same cycle as a grant takes precedence.
  always_comb begin
    alloc_cnt_d = alloc_cnt_q;
    free_cnt_d  = free_cnt_q;
    if (cnt_clr) begin
      alloc_cnt_d = '0;
      free_cnt_d  = '0;
    end else begin
      if (grant_alloc && (alloc_cnt_q != CNT_MAX)) alloc_cnt_d = alloc_cnt_q + 1'b1;
      if (grant_free && (free_cnt_q != CNT_MAX))   free_cnt_d  = free_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      last_alloc_q <= 1'b0;
      hold_data_q  <= '0;
      hold_alloc_q <= 1'b0;
      core_val_q   <= 1'b0;
      error_q      <= 1'b0;
      alloc_cnt_q  <= '0;
      free_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      last_alloc_q <= last_alloc_d;
      hold_data_q  <= hold_data_d;
      hold_alloc_q <= hold_alloc_d;
      core_val_q   <= core_val_d;
      error_q      <= error_d;
      alloc_cnt_q  <= alloc_cnt_d;
      free_cnt_q   <= free_cnt_d;
    end
  end

  assign alloc_req_rdy_o     = grant_alloc;
  assign free_req_rdy_o      = grant_free;
  assign core_req_val_o      = core_val_q;
  assign core_req_is_alloc_o = hold_alloc_q;
  assign core_req_data_o     = hold_data_q;
  assign busy_o              = (state_q != IDLE);
  assign error_o             = error_q;
  assign alloc_grant_cnt_o   = alloc_cnt_q;
  assign free_grant_cnt_o    = free_cnt_q;

endmodule
`default_nettype wire

// File: doc/falafel_req_scheduler.md
# falafel_req_scheduler

Serializes the allocator's two request streams onto the single shared allocator core. It arbitrates between the alloc-request and free-request FIFO outputs of the input parser and holds one request at a time. It issues that request to the core with a valid/ready handshake, then blocks until the core signals completion. The arbitration policy is set through the configuration-register write port, and the block keeps grant statistics.

## Interface
- DATA_W, 64, request payload width; must equal falafel_pkg DATA_W.
- MSG_ID_SIZE, 8, request ID width; must equal falafel_pkg MSG_ID_SIZE.
- CFG_ADDR, 'h10, config-register address decoded by this block.
- CNT_W, 16, width of each grant counter.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- alloc_req_val_i  in  1  alloc request valid.
- alloc_req_rdy_o  out  1  alloc request accepted.
- alloc_req_data_i  in  MSG_ID_SIZE+DATA_W  alloc_entry_t {id, data}.
- free_req_val_i  in  1  free request valid.
- free_req_rdy_o  out  1  free request accepted.
- free_req_data_i  in  MSG_ID_SIZE+DATA_W  alloc_entry_t {id, data}.
- core_req_val_o  out  1  request presented to the core.
- core_req_rdy_i  in  1  core accepts the request.
- core_req_is_alloc_o  out  1  1 = alloc, 0 = free.
- core_req_data_o  out  MSG_ID_SIZE+DATA_W  held alloc_entry_t.
- core_done_i  in  1  single-cycle pulse when the core finishes the request.
- config_reg_write_i  in  1  config write strobe.
- config_reg_addr_i  in  DATA_W  config address.
- config_reg_data_i  in  DATA_W  config data.
- busy_o  out  1  high while a request is held or outstanding.
- error_o  out  1  sticky flag for a protocol violation.
- alloc_grant_cnt_o  out  CNT_W  alloc grants since the last clear.
- free_grant_cnt_o  out  CNT_W  free grants since the last clear.

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - Arbitrate among the valid inputs.
  - Assert rdy only to the winner, combinationally, only if that input is valid.
  - On transfer, latch the data and is_alloc into the hold register, then go to ISSUE.
- ISSUE:
  - core_req_val_o=1 with the held request stable.
  - On core_req_val_o && core_req_rdy_i, go to WAIT_DONE.
- WAIT_DONE:
  - Both input rdy outputs are 0.
  - On core_done_i, go to IDLE.
- A core_done_i pulse in IDLE or ISSUE is ignored for the state transition and sets error_o.
- error_o clears only on reset.
- Arbitration mode is mode_q = cfg bit0:
  - mode 0 (round robin): with only one input valid, that input wins. With both valid, the winner is the type opposite to last_grant_q, which updates on every grant.
  - mode 1 (free priority): free wins whenever free_req_val_i is set.
- Config write: takes effect when config_reg_write_i=1 and config_reg_addr_i==CFG_ADDR.
  - mode_q <= data[0], effective from the next cycle's arbitration, including mid-request.
  - If data[8]=1, both counters clear to 0. A clear in the same cycle as a grant wins, so the counter is 0.
- Writes to any other address are ignored.
- Counters increment by 1 on each grant of their type and saturate at 2^CNT_W-1; they do not wrap.
- busy_o = (state != IDLE).

## Timing
- Reset values:
  - state=IDLE, mode_q=0, last_grant_q=free (so the first contended grant goes to alloc).
  - Hold register 0; core_req_val_o=0; core_req_is_alloc_o=0; core_req_data_o=0.
  - busy_o=0, error_o=0, both counters 0.
- Both input rdy outputs are 0 while rst_i is high.
- Reset mid-request drops the held request silently; the core is responsible for its own reset.
- Accept at cycle t gives core_req_val_o=1 at t+1. It stays high, with data stable, until the handshake cycle.
- Earliest core_done_i is the cycle after the handshake; the next accept is the cycle after done.
- Minimum 3 cycles per request; no back-to-back accepts.
- core_done_i in the same cycle as the handshake is a violation: set error_o and remain in WAIT_DONE.
- Inputs are never both granted in one cycle.
- Deasserting an input's valid before it is granted is legal and generates no grant.

## Test plan
- Reset, then a single alloc with data {id=3, data=0x40} and core rdy tied high, done two cycles later -> alloc_req_rdy_o at cycle 0, core_req_val_o at 1 with is_alloc=1 and data {3,0x40}, busy_o low at 4, alloc_grant_cnt_o=1.
- Mode 0, both inputs continuously valid, 4 requests -> grant order alloc, free, alloc, free; each counter ends at 2.
- Write CFG_ADDR data=0x1, then both inputs valid for 3 requests -> free, free, free; alloc_req_rdy_o never asserted.
- Hold core_req_rdy_i low for 5 cycles in ISSUE -> core_req_val_o high and data unchanged for all 5 cycles; input rdy outputs 0 throughout.
- Pulse core_done_i while IDLE -> error_o=1 and stays 1 through subsequent normal requests; after rst_i, error_o=0.
- Set CNT_W=2 and issue 5 alloc grants, then write data=0x100 -> counter reads 3 after grants 3, 4 and 5, and 0 after the clear; mode_q=0.
